// File: rtl/read_port_arbiter.sv
// Round-robin arbiter sharing one external 32:1 x 32-bit read mux among NREQ requesters.
// The grant is combinational, a requester may hold the port for up to MAXBURST cycles, and read data is registered one cycle later.
module read_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [4:0]        mux_address,
  input  logic [31:0]       mux_data,
  output logic [31:0]       rdata,
  output logic [NREQ-1:0]   rvalid
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IW-1:0] idx_t;

  idx_t            rr_ptr_q, rr_ptr_d;
  idx_t            owner_q, owner_d;
  logic            owner_valid_q, owner_valid_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic hold, rr_found, sel_valid;
  idx_t rr_idx, sel_idx;

  always_comb begin
    hold     = owner_valid_q && req[owner_q] && (burst_cnt_q < 4'(MAXBURST));
    rr_found = 1'b0;
    rr_idx   = '0;
    // Search starts just after the last new grant; rr_ptr itself is tried last.
    for (int k = 1; k <= NREQ; k++) begin
      if (!rr_found && req[(int'(rr_ptr_q) + k) % NREQ]) begin
        rr_found = 1'b1;
        rr_idx   = idx_t'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
    sel_valid = hold || rr_found;
    sel_idx   = hold ? owner_q : rr_idx;

    gnt         = '0;
    mux_address = '0;
    if (sel_valid && !Reset) begin
      gnt[sel_idx] = 1'b1;
      mux_address  = addr[5*int'(sel_idx) +: 5];
    end

    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    burst_cnt_d   = burst_cnt_q;
    if (sel_valid) begin
      if (hold) begin
        burst_cnt_d = burst_cnt_q + 4'd1;
      end else begin
        // Covers a different owner, no owner, and the owner re-won after hitting the limit.
        owner_d       = sel_idx;
        rr_ptr_d      = sel_idx;
        owner_valid_d = 1'b1;
        burst_cnt_d   = 4'd1;
      end
    end else begin
      owner_valid_d = 1'b0;
      burst_cnt_d   = 4'd0;
    end

    rdata_d  = sel_valid ? mux_data : rdata_q;
    rvalid_d = gnt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_q      <= idx_t'(NREQ - 1);
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= 4'd0;
      rdata_q       <= '0;
      rvalid_q      <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
endmodule

// File: tb/tb_read_port_arbiter.sv
// Directed bench for read_port_arbiter: grants are checked in-cycle,
// and read results are queued as expectations and compared one cycle later.
module tb_read_port_arbiter;
  localparam int NREQ = 4;
  localparam int MAXBURST = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] addr;
  logic [NREQ-1:0]   gnt;
  logic [4:0]        mux_address;
  logic [31:0]       mux_data;
  logic [31:0]       rdata;
  logic [NREQ-1:0]   rvalid;

  logic [4:0] a_tb [NREQ];
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_rd = '0;

  typedef struct packed {
    logic [NREQ-1:0] rv;
    logic [31:0]     rd;
  } exp_t;
  exp_t sb[$];

  read_port_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .addr(addr), .gnt(gnt),
    .mux_address(mux_address), .mux_data(mux_data), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memv(input logic [4:0] a);
    if (a == 5'd7) return 32'hDEADBEEF;
    return 32'h1100_0000 + {27'd0, a} * 32'h0001_0101;
  endfunction

  assign addr = {a_tb[3], a_tb[2], a_tb[1], a_tb[0]};
  assign mux_data = memv(mux_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive, check grant/select, queue the read result, check it after the edge.
  task automatic step(input logic rst, input logic [NREQ-1:0] r, input logic [NREQ-1:0] eg);
    logic [4:0] ea;
    exp_t e, o;
    Reset = rst;
    req = r;
    #1;
    ea = '0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) ea = a_tb[i];
    chk("gnt", {28'd0, gnt}, {28'd0, eg});
    chk("mux_address", {27'd0, mux_address}, {27'd0, ea});
    e.rv = rst ? '0 : eg;
    e.rd = rst ? 32'd0 : ((eg != '0) ? memv(ea) : exp_rd);
    exp_rd = e.rd;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      o = sb.pop_front();
      chk("rvalid", {28'd0, rvalid}, {28'd0, o.rv});
      chk("rdata", rdata, o.rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    a_tb[0] = 5'd3; a_tb[1] = 5'd5; a_tb[2] = 5'd7; a_tb[3] = 5'd12;
    Reset = 1'b1;
    req = '0;
    @(posedge Clk);
    #1;
    // Reset: grant forced off regardless of req, read path cleared.
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);

    // All requesting: bursts of MAXBURST in round-robin order, back to requester 0.
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b0001);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b0010);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b0100);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b1000);
    step(1'b0, 4'b1111, 4'b0001);

    // Owner 0 at burst 2 drops req: grant moves same cycle, new burst starts at 1.
    step(1'b0, 4'b0011, 4'b0001);
    step(1'b0, 4'b0010, 4'b0010);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0010);
    step(1'b0, 4'b0011, 4'b0001);

    // Idle: grant/select zero, rdata held, rr_ptr (=0) preserved.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b1111, 4'b0010);

    // Lone requester: no gaps across the hold-limit re-grant; per-cycle address honoured.
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0100, 4'b0100);
    a_tb[2] = 5'd9;
    step(1'b0, 4'b0100, 4'b0100);
    a_tb[2] = 5'd7;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0100);

    // Reset with a read in flight discards it; first grant then goes to lowest requested index.
    step(1'b0, 4'b0100, 4'b0100);
    step(1'b1, 4'b0100, 4'b0000);
    step(1'b0, 4'b1010, 4'b0010);
    step(1'b0, 4'b1000, 4'b1000);
    step(1'b0, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
